if_id_skid_seg: RTL and testbench

Parametrised successor to the IF/ID segment register. It carries fetched PC+4 and the instruction word into decode and splits the word into MIPS fields. It adds a valid/ready handshake, a 2-entry skid buffer so that a decode stall never drops a fetched instruction, flush with bubble insertion, and saturating stall/flush performance counters. It sits between the fetch unit and the decode/hazard logic.

---
 rtl/if_id_skid_seg.sv | 111 +++++++++++
 tb/tb_if_id_skid_seg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_seg.sv
// IF/ID segment with valid/ready handshake and a 2-entry skid buffer.
// Splits the head instruction into MIPS fields; counts stalls and flushes.
module if_id_skid_seg #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [PC_W-1:0]  PC_Add,
  input  logic [31:0]      IR_out,
  input  logic             Flush,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [PC_W-1:0]  PC_Add_out,
  output logic [5:0]       Op,
  output logic [4:0]       Rs,
  output logic [4:0]       Rt,
  output logic [4:0]       Rd,
  output logic [4:0]       Shamt,
  output logic [5:0]       Func,
  output logic [1:0]       Occupancy,
  output logic [CNT_W-1:0] Stall_cnt,
  output logic [CNT_W-1:0] Flush_cnt
);

  typedef struct packed {
    logic            vld;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
  } ent_t;

  ent_t head_q, skid_q;
  ent_t head_d, skid_d;
  ent_t in_ent;
  logic rdy_q;
  logic accept, consume, stall;

  assign in_ent  = {1'b1, PC_Add, IR_out};
  assign accept  = In_valid & rdy_q;
  assign consume = head_q.vld & Out_ready;
  assign stall   = head_q.vld & ~Out_ready;

  // Next head/skid contents; invalid entries are kept all-zero so the
  // outputs read as a NOP bubble without extra masking.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    priority case (1'b1)
      Flush: begin
        head_d = '0;
        skid_d = '0;
      end
      skid_q.vld: begin
        if (consume) begin
          head_d = skid_q;
          skid_d = '0;
        end
      end
      head_q.vld: begin
        if (consume)
          head_d = accept ? in_ent : '0;
        else if (accept)
          skid_d = in_ent;
      end
      default: begin
        if (accept)
          head_d = in_ent;
      end
    endcase
  end

  // Entry storage and registered ready (high while the skid slot is free).
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      rdy_q  <= ~(head_d.vld & skid_d.vld);
    end
  end

  // Saturating stall and flush counters, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Stall_cnt <= '0;
      Flush_cnt <= '0;
    end else begin
      if (stall && Stall_cnt != '1)
        Stall_cnt <= Stall_cnt + 1'b1;
      if (Flush && Flush_cnt != '1)
        Flush_cnt <= Flush_cnt + 1'b1;
    end
  end

  assign In_ready   = rdy_q;
  assign Out_valid  = head_q.vld;
  assign PC_Add_out = head_q.pc;
  assign Op         = head_q.ir[31:26];
  assign Rs         = head_q.ir[25:21];
  assign Rt         = head_q.ir[20:16];
  assign Rd         = head_q.ir[15:11];
  assign Shamt      = head_q.ir[10:6];
  assign Func       = head_q.ir[5:0];
  assign Occupancy  = {1'b0, head_q.vld} + {1'b0, skid_q.vld};

endmodule

// File: tb/tb_if_id_skid_seg.sv
// Directed bench for if_id_skid_seg (CNT_W=4 to reach saturation).
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_if_id_skid_seg;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] PC_Add;
  logic [31:0] IR_out;
  logic        Flush;
  logic        Out_valid;
  logic        Out_ready;
  logic [31:0] PC_Add_out;
  logic [5:0]  Op;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [5:0]  Func;
  logic [1:0]  Occupancy;
  logic [3:0]  Stall_cnt;
  logic [3:0]  Flush_cnt;

  int checks = 0;
  int failures = 0;

  if_id_skid_seg #(.PC_W(32), .CNT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .In_valid(In_valid), .In_ready(In_ready),
    .PC_Add(PC_Add), .IR_out(IR_out),
    .Flush(Flush),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .PC_Add_out(PC_Add_out),
    .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Shamt(Shamt), .Func(Func),
    .Occupancy(Occupancy),
    .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0;
    In_valid = 1'b0;
    PC_Add = '0;
    IR_out = '0;
    Flush = 1'b0;
    Out_ready = 1'b0;
    step();
    step();
    chk("rst_ov", 32'(Out_valid), 0);
    chk("rst_occ", 32'(Occupancy), 0);
    chk("rst_ir", 32'(In_ready), 1);
    chk("rst_pc", PC_Add_out, 0);
    chk("rst_sc", 32'(Stall_cnt), 0);
    chk("rst_fc", 32'(Flush_cnt), 0);
    Rst_n = 1'b1;

    // single accept
    In_valid = 1'b1;
    PC_Add = 32'h4;
    IR_out = 32'h012A4020;
    step();
    In_valid = 1'b0;
    chk("t1_ov", 32'(Out_valid), 1);
    chk("t1_op", 32'(Op), 0);
    chk("t1_rs", 32'(Rs), 9);
    chk("t1_rt", 32'(Rt), 10);
    chk("t1_rd", 32'(Rd), 8);
    chk("t1_sh", 32'(Shamt), 0);
    chk("t1_fn", 32'(Func), 32'h20);
    chk("t1_pc", PC_Add_out, 32'h4);
    chk("t1_occ", 32'(Occupancy), 1);
    Out_ready = 1'b1;
    step();
    chk("t1_drain_ov", 32'(Out_valid), 0);
    chk("t1_drain_sc", 32'(Stall_cnt), 0);

    // back-pressure into the skid slot
    Out_ready = 1'b0;
    In_valid = 1'b1;
    PC_Add = 32'h8;
    IR_out = 32'h8C220004;
    step();
    PC_Add = 32'hC;
    IR_out = 32'hAC230008;
    step();
    chk("bp_occ2", 32'(Occupancy), 2);
    chk("bp_ir0", 32'(In_ready), 0);
    chk("bp_pc", PC_Add_out, 32'h8);
    chk("bp_op", 32'(Op), 32'h23);
    chk("bp_sc1", 32'(Stall_cnt), 1);
    PC_Add = 32'h10;
    IR_out = 32'hDEADBEEF;
    step();
    In_valid = 1'b0;
    chk("bp_hold_pc", PC_Add_out, 32'h8);
    chk("bp_hold_rt", 32'(Rt), 2);
    chk("bp_hold_occ", 32'(Occupancy), 2);
    chk("bp_sc2", 32'(Stall_cnt), 2);
    Out_ready = 1'b1;
    step();
    chk("bp_d1_pc", PC_Add_out, 32'hC);
    chk("bp_d1_op", 32'(Op), 32'h2B);
    chk("bp_d1_rs", 32'(Rs), 1);
    chk("bp_d1_rt", 32'(Rt), 3);
    chk("bp_d1_occ", 32'(Occupancy), 1);
    chk("bp_d1_ir", 32'(In_ready), 1);
    step();
    chk("bp_d2_ov", 32'(Out_valid), 0);
    chk("bp_d2_pc", PC_Add_out, 0);
    chk("bp_d2_occ", 32'(Occupancy), 0);
    chk("bp_d2_ir", 32'(In_ready), 1);
    chk("bp_d2_sc", 32'(Stall_cnt), 2);

    // streaming, one word per cycle
    In_valid = 1'b1;
    Out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      PC_Add = 32'(4 + 4 * i);
      IR_out = 32'h20 | (32'(i) << 11);
      step();
      chk("st_pc", PC_Add_out, 32'(4 + 4 * i));
      chk("st_rd", 32'(Rd), 32'(i));
      chk("st_occ", 32'(Occupancy), 1);
    end
    In_valid = 1'b0;
    step();
    chk("st_end_occ", 32'(Occupancy), 0);
    chk("st_end_sc", 32'(Stall_cnt), 2);

    // flush with both entries held and an incoming word
    Out_ready = 1'b0;
    In_valid = 1'b1;
    PC_Add = 32'h100;
    IR_out = 32'h012A4020;
    step();
    PC_Add = 32'h104;
    step();
    chk("fl_pre_occ", 32'(Occupancy), 2);
    PC_Add = 32'h108;
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    In_valid = 1'b0;
    chk("fl_ov", 32'(Out_valid), 0);
    chk("fl_pc", PC_Add_out, 0);
    chk("fl_fn", 32'(Func), 0);
    chk("fl_rs", 32'(Rs), 0);
    chk("fl_occ", 32'(Occupancy), 0);
    chk("fl_ir", 32'(In_ready), 1);
    chk("fl_fc", 32'(Flush_cnt), 1);
    chk("fl_sc", 32'(Stall_cnt), 4);
    Out_ready = 1'b1;
    step();
    chk("fl_after_ov", 32'(Out_valid), 0);

    // reset wins over flush
    Out_ready = 1'b0;
    In_valid = 1'b1;
    PC_Add = 32'h200;
    IR_out = 32'hFFFFFFFF;
    step();
    In_valid = 1'b0;
    chk("rp_pre_occ", 32'(Occupancy), 1);
    Rst_n = 1'b0;
    Flush = 1'b1;
    step();
    Rst_n = 1'b1;
    Flush = 1'b0;
    chk("rp_ov", 32'(Out_valid), 0);
    chk("rp_occ", 32'(Occupancy), 0);
    chk("rp_pc", PC_Add_out, 0);
    chk("rp_fn", 32'(Func), 0);
    chk("rp_fc", 32'(Flush_cnt), 0);
    chk("rp_sc", 32'(Stall_cnt), 0);
    chk("rp_ir", 32'(In_ready), 1);

    // stall counter saturation
    In_valid = 1'b1;
    PC_Add = 32'h300;
    IR_out = 32'h00001234;
    step();
    In_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat_sc", 32'(Stall_cnt), (i < 15) ? 32'(i) : 32'd15);
    end
    chk("sat_pc", PC_Add_out, 32'h300);
    chk("sat_fn", 32'(Func), 32'h34);

    // flush counter saturation
    Flush = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("fsat_fc", 32'(Flush_cnt), (i < 15) ? 32'(i) : 32'd15);
    end
    Flush = 1'b0;
    chk("fsat_sc", 32'(Stall_cnt), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
